// File: rtl/cacheline_adaptor_pkg.sv
// Shared constants and state encoding for the cache-line to memory-burst adaptor.
package cacheline_adaptor_pkg;

   localparam int DEF_LINE_WIDTH  = 256;
   localparam int DEF_BURST_WIDTH = 64;
   localparam int DEF_ADDR_WIDTH  = 32;
   localparam int BEATS           = DEF_LINE_WIDTH / DEF_BURST_WIDTH;
   localparam int OFFSET_BITS     = $clog2(DEF_LINE_WIDTH / 8);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } adaptor_state_e;

   // A single-beat line still needs a one-bit counter to keep the ports legal.
   function automatic int cnt_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/cacheline_adaptor_line_buffer.sv
// Line-wide register: full-line load from the cache, per-beat fill from memory,
// and a beat-select read mux feeding the memory write data.
module line_buffer #(
   parameter int LINE_WIDTH  = 256,
   parameter int BURST_WIDTH = 64,
   parameter int IDX_W       = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load_en,
   input  logic [LINE_WIDTH-1:0]  load_data,
   input  logic                   beat_we,
   input  logic [IDX_W-1:0]       beat_idx,
   input  logic [BURST_WIDTH-1:0] beat_data,
   output logic [LINE_WIDTH-1:0]  line_q,
   output logic [BURST_WIDTH-1:0] beat_q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_q <= '0;
      end else if (load_en) begin
         line_q <= load_data;
      end else if (beat_we) begin
         line_q[beat_idx*BURST_WIDTH +: BURST_WIDTH] <= beat_data;
      end
   end

   assign beat_q = line_q[beat_idx*BURST_WIDTH +: BURST_WIDTH];

endmodule

// File: rtl/cacheline_adaptor.sv
// Services one full-line cache read or write as a fixed-length burst of
// narrower memory beats, then pulses downstream_resp for one cycle.
module cacheline_adaptor
   import cacheline_adaptor_pkg::*;
#(
   parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
   parameter int BURST_WIDTH = DEF_BURST_WIDTH,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   downstream_read,
   input  logic                   downstream_write,
   input  logic [ADDR_WIDTH-1:0]  downstream_address,
   input  logic [LINE_WIDTH-1:0]  downstream_wdata,
   output logic [LINE_WIDTH-1:0]  downstream_rdata,
   output logic                   downstream_resp,
   output logic                   burst_read,
   output logic                   burst_write,
   output logic [ADDR_WIDTH-1:0]  burst_address,
   output logic [BURST_WIDTH-1:0] burst_wdata,
   input  logic [BURST_WIDTH-1:0] burst_rdata,
   input  logic                   burst_resp
);

   localparam int N_BEATS  = LINE_WIDTH / BURST_WIDTH;
   localparam int CNT_W    = cnt_width(N_BEATS);
   localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);
   localparam logic [CNT_W-1:0]      LAST     = CNT_W'(N_BEATS - 1);
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);

   adaptor_state_e          state;
   logic [CNT_W-1:0]        count;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    load_en;
   logic                    beat_we;
   logic [LINE_WIDTH-1:0]   line_q;
   logic [BURST_WIDTH-1:0]  beat_q;

   // Read wins when both requests are up, so a write only loads the buffer alone.
   assign load_en = (state == ST_IDLE) && !downstream_read && downstream_write;
   assign beat_we = (state == ST_READ) && burst_resp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         count  <= '0;
         addr_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               count <= '0;
               if (downstream_read) begin
                  addr_q <= downstream_address & ~OFF_MASK;
                  state  <= ST_READ;
               end else if (downstream_write) begin
                  addr_q <= downstream_address & ~OFF_MASK;
                  state  <= ST_WRITE;
               end
            end
            ST_READ, ST_WRITE: begin
               if (burst_resp) begin
                  if (count == LAST) begin
                     count <= '0;
                     state <= ST_DONE;
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   line_buffer #(
      .LINE_WIDTH  (LINE_WIDTH),
      .BURST_WIDTH (BURST_WIDTH),
      .IDX_W       (CNT_W)
   ) u_line_buffer (
      .clk       (clk),
      .rst       (rst),
      .load_en   (load_en),
      .load_data (downstream_wdata),
      .beat_we   (beat_we),
      .beat_idx  (count),
      .beat_data (burst_rdata),
      .line_q    (line_q),
      .beat_q    (beat_q)
   );

   // Burst requests decode straight from state so an async reset drops them at once.
   assign burst_read       = (state == ST_READ);
   assign burst_write      = (state == ST_WRITE);
   assign downstream_resp  = (state == ST_DONE);
   assign downstream_rdata = line_q;
   assign burst_address    = addr_q;
   assign burst_wdata      = beat_q;

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Memory-side responder for the cache hierarchy's line interface. It accepts one full-line read or write from a cache controller using the level/response handshake: the request is held until a one-cycle `downstream_resp`. It services that request as a fixed-length burst of narrower beats to physical memory. It sits between the last-level cache's downstream port and the burst memory model or controller.

## Interface
Parameters:
- `LINE_WIDTH`, 256, cache line width in bits; must be an integer multiple of `BURST_WIDTH`
- `BURST_WIDTH`, 64, memory beat width in bits
- `ADDR_WIDTH`, 32, byte address width

Ports:
- One clock; reset is asynchronous and active-high.
- `clk`  in  1  clock, all state updates on the rising edge
- `rst`  in  1  asynchronous active-high reset
- `downstream_read`  in  1  cache line read request, held until `downstream_resp`
- `downstream_write`  in  1  cache line write request, held until `downstream_resp`
- `downstream_address`  in  ADDR_WIDTH  line byte address
- `downstream_wdata`  in  LINE_WIDTH  line to write
- `downstream_rdata`  out  LINE_WIDTH  line read; valid while `downstream_resp`=1
- `downstream_resp`  out  1  one-cycle completion pulse to the cache
- `burst_read`  out  1  memory burst read request
- `burst_write`  out  1  memory burst write request
- `burst_address`  out  ADDR_WIDTH  line-aligned burst address
- `burst_wdata`  out  BURST_WIDTH  current write beat
- `burst_rdata`  in  BURST_WIDTH  current read beat, valid with `burst_resp`
- `burst_resp`  in  1  memory accepts or returns one beat this cycle

## Operation
- `BEATS = LINE_WIDTH/BURST_WIDTH` (4 at defaults).
- Beat k maps to line bits [k*BURST_WIDTH +: BURST_WIDTH], for k = 0..BEATS-1, in ascending order.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - `downstream_read`=1 → latch the address and go to READ.
  - Otherwise `downstream_write`=1 → latch the address and `downstream_wdata`, then go to WRITE.
  - If both are 1, read wins and the write is ignored.
  - Beat counter cleared.
- Latched address has its low log2(LINE_WIDTH/8) bits forced to 0, and drives `burst_address`.
- READ:
  - `burst_read`=1.
  - On each `burst_resp`, store `burst_rdata` into slot `count` of the line buffer and increment `count`.
  - On the beat with `count`==BEATS-1, go to DONE.
- WRITE:
  - `burst_write`=1 and `burst_wdata` = slot `count` of the latched line.
  - On each `burst_resp`, increment `count`.
  - On the last beat, go to DONE.
- Beats may be separated by any number of cycles with `burst_resp`=0. The request stays asserted and the counter holds during those gaps.
- DONE:
  - `downstream_resp`=1 for exactly one cycle.
  - `downstream_rdata` = line buffer (after a write it is the written line).
  - Next state is IDLE.
- Request inputs are sampled only in IDLE. Their level in READ, WRITE and DONE is ignored, which covers the cache dropping write in its resp cycle and the cache holding read through resp.
- `burst_resp` in IDLE or DONE is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, count 0, line buffer 0, latched address 0.
- Reset mid-burst aborts immediately: burst request drops asynchronously and no `downstream_resp` is issued.
- `burst_read`/`burst_write` are decoded from registered state, so they assert the cycle after the request is seen in IDLE.
- Minimum latency with back-to-back beats: request seen in IDLE at cycle 0, beats at cycles 1–4, `downstream_resp` at cycle 5.
- A new request visible in the cycle after DONE (IDLE) is accepted at once. This supports the cache's read-then-writeback sequence with no dead cycle.
- `burst_read` and `burst_write` are never 1 simultaneously.
- `burst_read` or `burst_write` drops in the cycle after the last `burst_resp` (the DONE cycle).
- Counter width is log2(BEATS). It wraps to 0 on the last beat and never exceeds BEATS-1.

## Structure
- Shared package `rv32i_types` (or the cache package) holds `BEATS`, the offset-bit constant and the adaptor state enum.
- One sub-module, `line_buffer`: LINE_WIDTH register with beat-indexed write enable, a full-line load port, and a beat-select read mux.

## Test plan
- Read, burst_resp on 4 consecutive cycles with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → `downstream_rdata` = {0x44..44, 0x33..33, 0x22..22, 0x11..11}, `downstream_resp` high exactly at cycle 5.
- Write of line 0xDEAD…(known pattern) to address 0x0000_1234 → `burst_address`=0x0000_1220 and `burst_wdata` steps through the 4 slices in order, low beat first.
- Read with 3 idle cycles before each beat → counter holds, `burst_read` stays 1, `downstream_resp` at cycle 1+4+12=17.
- Read completes, then write asserted the next cycle (cache writeback pattern) → write accepted that cycle, `burst_write` the cycle after, no duplicate read burst.
- `rst` pulsed after beat 2 of a read → outputs 0 immediately, no `downstream_resp`; a following read returns correct fresh data.
- `downstream_read` and `downstream_write` both 1 in IDLE → read burst only; a stray `burst_resp` in IDLE → no state change.
